nios2test_nios2_gen2_0_cpu_debug_oci_arbiter: RTL and testbench

Sequences and shares the single on-chip-instrumentation (OCI) register/memory access port of the Nios II debug module between two requesters: the JTAG debug-slave command path (requester 0, sysclk domain, after take_action decoding) and an on-chip host debug port (requester 1). It arbitrates round-robin, issues one command at a time to the OCI port, tracks write acceptance and read-data return, and reports completion, read data and timeout errors back to the winning requester.

---
 rtl/nios2test_nios2_gen2_0_cpu_debug_oci_arbiter.sv | 155 +++++++++++++++
 tb/tb_nios2test_nios2_gen2_0_cpu_debug_oci_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2test_nios2_gen2_0_cpu_debug_oci_arbiter.sv
// Round-robin arbiter sharing the debug OCI access port between the JTAG command
// path (requester 0) and the on-chip host debug port (requester 1).
module nios2test_nios2_gen2_0_cpu_debug_oci_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              debugack_i,
    input  logic              j_req_i,
    input  logic              j_wr_i,
    input  logic [ADDR_W-1:0] j_addr_i,
    input  logic [31:0]       j_wdata_i,
    input  logic              h_req_i,
    input  logic              h_wr_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [31:0]       h_wdata_i,
    output logic              j_gnt_o,
    output logic              j_done_o,
    output logic [31:0]       j_rdata_o,
    output logic              j_err_o,
    output logic              h_gnt_o,
    output logic              h_done_o,
    output logic [31:0]       h_rdata_o,
    output logic              h_err_o,
    output logic              oci_cmd_valid_o,
    output logic              oci_wr_o,
    output logic [ADDR_W-1:0] oci_addr_o,
    output logic [31:0]       oci_wdata_o,
    input  logic              oci_ready_i,
    input  logic              oci_rvalid_i,
    input  logic [31:0]       oci_rdata_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              win_q, win_d;
    logic              gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic j_elig, h_elig, sel;

    assign j_elig = j_req_i;
    assign h_elig = h_req_i & debugack_i;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        gnt_d      = 1'b0;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        sel        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (j_elig || h_elig) begin
                    // On a tie the requester not granted last time wins.
                    sel        = (j_elig && h_elig) ? ~last_gnt_q : h_elig;
                    win_d      = sel;
                    last_gnt_d = sel;
                    gnt_d      = 1'b1;
                    wr_d       = sel ? h_wr_i : j_wr_i;
                    addr_d     = sel ? h_addr_i : j_addr_i;
                    wdata_d    = sel ? h_wdata_i : j_wdata_i;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + 16'd1;
                if (oci_ready_i) begin
                    state_d = wr_q ? StDone : StWait;
                end else if (cnt_q == TimeoutCnt) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                if (oci_rvalid_i) begin
                    rdata_d = oci_rdata_i;
                    state_d = StDone;
                end else if (cnt_q == TimeoutCnt) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            gnt_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign j_gnt_o   = gnt_q & ~win_q;
    assign h_gnt_o   = gnt_q & win_q;
    assign j_done_o  = (state_q == StDone) & ~win_q;
    assign h_done_o  = (state_q == StDone) & win_q;
    // rdata_q is cleared at grant and only loaded on a read return, so writes
    // and timeouts report zero.
    assign j_rdata_o = j_done_o ? rdata_q : '0;
    assign h_rdata_o = h_done_o ? rdata_q : '0;
    assign j_err_o   = j_done_o & err_q;
    assign h_err_o   = h_done_o & err_q;

    assign oci_cmd_valid_o = (state_q == StIssue);
    assign oci_wr_o        = wr_q;
    assign oci_addr_o      = addr_q;
    assign oci_wdata_o     = wdata_q;

endmodule

// File: tb/tb_nios2test_nios2_gen2_0_cpu_debug_oci_arbiter.sv
// Directed bench for the OCI arbiter: grant order, read/write completion,
// debugack gating, timeout, reset abort and command hold under back-pressure.
module tb_nios2test_nios2_gen2_0_cpu_debug_oci_arbiter;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset, debugack;
    logic              j_req, j_wr, h_req, h_wr;
    logic [ADDR_W-1:0] j_addr, h_addr;
    logic [31:0]       j_wdata, h_wdata;
    logic              j_gnt, j_done, j_err, h_gnt, h_done, h_err;
    logic [31:0]       j_rdata, h_rdata;
    logic              oci_cmd_valid, oci_wr, oci_ready, oci_rvalid;
    logic [ADDR_W-1:0] oci_addr;
    logic [31:0]       oci_wdata, oci_rdata;

    int passed = 0;
    int total  = 0;
    logic [1:0]  exp_pair;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;

    always #5 clk = ~clk;

    nios2test_nios2_gen2_0_cpu_debug_oci_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .debugack_i      (debugack),
        .j_req_i         (j_req),
        .j_wr_i          (j_wr),
        .j_addr_i        (j_addr),
        .j_wdata_i       (j_wdata),
        .h_req_i         (h_req),
        .h_wr_i          (h_wr),
        .h_addr_i        (h_addr),
        .h_wdata_i       (h_wdata),
        .j_gnt_o         (j_gnt),
        .j_done_o        (j_done),
        .j_rdata_o       (j_rdata),
        .j_err_o         (j_err),
        .h_gnt_o         (h_gnt),
        .h_done_o        (h_done),
        .h_rdata_o       (h_rdata),
        .h_err_o         (h_err),
        .oci_cmd_valid_o (oci_cmd_valid),
        .oci_wr_o        (oci_wr),
        .oci_addr_o      (oci_addr),
        .oci_wdata_o     (oci_wdata),
        .oci_ready_i     (oci_ready),
        .oci_rvalid_i    (oci_rvalid),
        .oci_rdata_i     (oci_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; debugack = 1'b0;
        j_req = 1'b0; j_wr = 1'b0; j_addr = '0; j_wdata = '0;
        h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = '0;
        oci_ready = 1'b0; oci_rvalid = 1'b0; oci_rdata = '0;
        do_reset();

        chk("rst_j", {j_gnt, j_done, j_err, j_rdata}, 64'd0);
        chk("rst_h", {h_gnt, h_done, h_err, h_rdata}, 64'd0);
        chk("rst_oci", {oci_cmd_valid, oci_wr, oci_addr, oci_wdata}, 64'd0);

        // Read from requester 0; rvalid two cycles after the command goes valid.
        j_req = 1'b1; j_wr = 1'b0; j_addr = 8'h10;
        step();
        chk("rd_gnt", {j_gnt, h_gnt, oci_cmd_valid, oci_wr, oci_addr}, {3'b101, 1'b0, 8'h10});
        j_req = 1'b0; oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        chk("rd_wait_nodone", {j_gnt, j_done, oci_cmd_valid}, 64'd0);
        step();
        oci_rvalid = 1'b1; oci_rdata = 32'hCAFE_0001;
        step();
        oci_rvalid = 1'b0;
        chk("rd_done", {j_done, j_err, j_rdata}, {2'b10, 32'hCAFE_0001});
        chk("rd_h_quiet", {h_gnt, h_done, h_err, h_rdata}, 64'd0);
        step();
        chk("rd_done_pulse", {j_done, j_rdata}, 64'd0);

        // Both requesters held high: grants alternate starting with requester 0.
        do_reset();
        debugack = 1'b1;
        j_req = 1'b1; j_wr = 1'b1; j_addr = 8'h21; j_wdata = 32'h1111_1111;
        h_req = 1'b1; h_wr = 1'b1; h_addr = 8'h42; h_wdata = 32'h2222_2222;
        for (int i = 0; i < 8; i++) begin
            exp_pair  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr  = (i % 2 == 0) ? 8'h21 : 8'h42;
            exp_wdata = (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
            step();
            chk($sformatf("rr_gnt%0d", i), {j_gnt, h_gnt}, exp_pair);
            chk($sformatf("rr_cmd%0d", i), {oci_cmd_valid, oci_wr, oci_addr, oci_wdata},
                {2'b11, exp_addr, exp_wdata});
            oci_ready = 1'b1;
            step();
            oci_ready = 1'b0;
            chk($sformatf("rr_done%0d", i), {j_done, h_done, j_rdata, h_rdata}, {exp_pair, 64'd0});
            step();
        end
        j_req = 1'b0; h_req = 1'b0;

        // Requester 1 is locked out while debugack is low.
        do_reset();
        debugack = 1'b0; h_req = 1'b1; h_wr = 1'b1; h_addr = 8'h33; h_wdata = 32'h5;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("dbg_nogrant%0d", i), {h_gnt, oci_cmd_valid}, 64'd0);
        end
        debugack = 1'b1;
        step();
        chk("dbg_grant", {h_gnt, j_gnt, oci_cmd_valid, oci_addr}, {3'b101, 8'h33});
        h_req = 1'b0; oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        chk("dbg_done", {h_done, h_err, j_done}, 3'b100);
        step();

        // Read accepted but never returned: timeout TIMEOUT+1 cycles after grant.
        do_reset();
        j_req = 1'b1; j_wr = 1'b0; j_addr = 8'h77;
        step();
        chk("to_gnt", j_gnt, 1'b1);
        j_req = 1'b0; oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), j_done, 1'b0);
        end
        step();
        chk("to_done", {j_done, j_err, j_rdata}, {2'b11, 32'd0});
        oci_rvalid = 1'b1; oci_rdata = 32'hDEAD_BEEF;
        step();
        chk("to_stray1", {j_done, j_err, j_rdata, oci_cmd_valid}, 64'd0);
        step();
        oci_rvalid = 1'b0;
        chk("to_stray2", {j_done, j_gnt, j_rdata}, 64'd0);

        // Reset while waiting for read data aborts silently.
        do_reset();
        j_req = 1'b1; j_wr = 1'b0; j_addr = 8'h55;
        step();
        j_req = 1'b0; oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_rst_j", {j_gnt, j_done, j_err, j_rdata}, 64'd0);
        chk("rw_rst_oci", {oci_cmd_valid, oci_wr, oci_addr, oci_wdata}, 64'd0);
        oci_rvalid = 1'b1; oci_rdata = 32'h1234_5678;
        step();
        oci_rvalid = 1'b0;
        chk("rw_late_rvalid", {j_done, h_done, j_rdata}, 64'd0);
        debugack = 1'b1; j_req = 1'b1; h_req = 1'b1; j_wr = 1'b1; h_wr = 1'b1;
        step();
        chk("rw_tie_j", {j_gnt, h_gnt}, 2'b10);
        j_req = 1'b0; h_req = 1'b0; oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        step();

        // Back-pressure: command fields stay stable while oci_ready is low.
        do_reset();
        j_req = 1'b1; j_wr = 1'b1; j_addr = 8'h5A; j_wdata = 32'h1234_5678;
        step();
        j_req = 1'b0; j_addr = 8'h00; j_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {oci_cmd_valid, oci_wr, oci_addr, oci_wdata, j_done},
                {2'b11, 8'h5A, 32'h1234_5678, 1'b0});
            step();
        end
        chk("bp_accept", {oci_cmd_valid, oci_addr, oci_wdata}, {1'b1, 8'h5A, 32'h1234_5678});
        oci_ready = 1'b1;
        step();
        oci_ready = 1'b0;
        chk("bp_done", {j_done, j_err, oci_cmd_valid}, 3'b100);
        step();
        chk("bp_idle", {j_done, oci_cmd_valid}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
